xz_result_fifo: RTL and testbench
=================================

# xz_result_fifo

Downstream buffer stage for the 64-bit datapath's registered 32-bit result pair (x, z). It captures one (x, z) pair per qualified cycle into a DEPTH-entry FIFO. It replays each stored pair as two consecutive WIDTH-bit words, x first and then z, over a valid/ready stream. This decouples the fixed-rate datapath from a slower consumer such as a bus writer or a UART bridge.

## Interface
- WIDTH, 32, width of each result word (x, z, out_data)
- DEPTH, 4, number of (x, z) pair entries; power of two, ≥ 2
- CLK  input  1  clock, rising edge
- RST  input  1  asynchronous reset, active-low (0 = reset)
- flush  input  1  synchronous clear of FIFO contents and serializer state
- in_valid  input  1  upstream has a new (x, z) pair this cycle
- in_ready  output  1  an entry is free and a push will be accepted
- x  input  WIDTH  first result word of the pair
- z  input  WIDTH  second result word of the pair
- out_valid  output  1  out_data holds a valid word
- out_ready  input  1  consumer accepts out_data this cycle
- out_data  output  WIDTH  current word: head.x or head.z
- out_last  output  1  high when out_data is the z word (second word of the pair)
- count  output  $clog2(DEPTH)+1  number of stored pairs, 0..DEPTH
- drop_cnt  output  16  saturating count of rejected pushes (present only with the macro below)

## Operation
- Storage: DEPTH entries, each 2*WIDTH bits {x, z}. Write pointer and read pointer are $clog2(DEPTH) bits and wrap modulo DEPTH. Storage is not reset.
- Push: occurs when in_valid && in_ready. {x, z} is written at wptr, wptr increments.
- in_ready = (count < DEPTH). It is registered-full based, with no pass-through when full, even if a pop happens in the same cycle.
- Serializer FSM has two states:
  - WORD_X: out_data = mem[rptr].x, out_last = 0.
  - WORD_Z: out_data = mem[rptr].z, out_last = 1.
- out_valid = (count != 0).
- Beat occurs when out_valid && out_ready:
  - In WORD_X, go to WORD_Z.
  - In WORD_Z, go to WORD_X, pop (rptr+1).
- No beat: state and out_data hold stable while out_valid is high.
- Push and pop in the same cycle: count is unchanged, and both pointers advance.
- flush = 1: on the next edge, wptr = rptr = 0, count = 0, state = WORD_X. flush has priority over push and pop in that cycle; a coincident push is discarded and is not counted as a drop.
- Reset mid-transfer: a partially sent pair (x sent, z not) is lost. After reset the state is WORD_X.

## Timing
- Reset values:
  - count = 0, out_valid = 0, out_last = 0, in_ready = 1.
  - out_data = mem[0].x, which is undefined content; consumers must qualify it with out_valid.
  - drop_cnt = 0.
- Latency: a pair pushed at edge N gives out_valid = 1 after edge N, and its x word is presentable in cycle N+1 if the FIFO was empty.
- Throughput: one word per cycle out, so one pair per 2 cycles. Input can burst up to DEPTH pairs back-to-back.
- out_data, out_last and out_valid are driven combinationally from registered state and storage. in_ready is driven from the count register only.
- Full: count == DEPTH gives in_ready = 0. A push is accepted again in the cycle after the z beat of the head pair.
- Empty: with count == 0, out_ready is ignored, and state stays WORD_X.

## Configuration
- XZ_RESULT_FIFO_DROP_CNT_EN defined:
  - drop_cnt port and register are present.
  - drop_cnt increments on each cycle with in_valid && !in_ready && !flush, and saturates at 16'hFFFF.
  - It clears on reset only; flush does not clear it.
- Undefined: the drop_cnt port and logic are absent. Rejected pushes are silently discarded.

## Test plan
- Reset then single pair:
  - Stimulus: RST low→high, push x=32'h0000_0011, z=32'h0000_0022, out_ready=1.
  - Required: out_data 0x11 with out_last=0, next cycle 0x22 with out_last=1, then out_valid=0 and count=0.
- Fill and stall:
  - Stimulus: out_ready=0, push 5 pairs (x=i, z=i+0x100, i=1..5).
  - Required: count reaches 4, in_ready=0 after the 4th, the 5th is rejected, and drop_cnt=1 with macro.
  - Stimulus: release out_ready.
  - Required: words 1,0x101,2,0x102,3,0x103,4,0x104.
- Backpressure mid-pair:
  - Stimulus: out_ready toggles 1,0,0,1 on a pair (0xA, 0xB).
  - Required: 0xA on beat 1, 0xB held with out_last=1 through the stalls, popped on the final beat.
- Simultaneous push/pop at full:
  - Stimulus: FIFO full, z beat accepted while in_valid=1.
  - Required: the push is rejected that cycle (in_ready=0), count drops to 3, and the push is accepted in the next cycle.
- Pointer wrap:
  - Stimulus: stream 10 pairs with out_ready=1 and in_valid every 2nd cycle.
  - Required: all 20 words appear in order and count never exceeds 1.
- Flush and async reset:
  - Stimulus: after 3 pushes and the x beat of the head pair, assert flush with in_valid=1.
  - Required: next cycle count=0, out_valid=0, state WORD_X, drop_cnt unchanged.
  - Stimulus: repeat with RST asserted mid-cycle instead.
  - Required: all outputs take reset values immediately, without waiting for a CLK edge.

Source files
------------

// File: rtl/xz_result_fifo.sv
// Result-pair FIFO: stores (x, z) pairs and replays each as two words, x then z.
// Optional rejected-push counter enabled by defining XZ_RESULT_FIFO_DROP_CNT_EN.
//
// state  | meaning
// WORD_X | head pair x word on out_data, out_last = 0
// WORD_Z | head pair z word on out_data, out_last = 1; beat pops the pair
module xz_result_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           x,
  input  logic [WIDTH-1:0]           z,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_last,
  output logic [$clog2(DEPTH):0]     count
`ifdef XZ_RESULT_FIFO_DROP_CNT_EN
  ,
  output logic [15:0]                drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {WORD_X = 1'b0, WORD_Z = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [2*WIDTH-1:0]     mem [DEPTH];
  logic [AW-1:0]          wptr, rptr;
  logic                   push, beat, pop;

  // in_ready comes only from the registered count, so a full FIFO never
  // accepts a push even when the head pair pops in the same cycle.
  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign beat      = out_valid && out_ready;
  assign pop       = beat && (state_q == WORD_Z) && !flush;

  always_ff @(posedge CLK) begin
    if (push) mem[wptr] <= {x, z};
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      state_q <= WORD_X;
    end else if (flush) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      state_q <= WORD_X;
    end else begin
      state_q <= state_d;
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    out_last = 1'b0;
    out_data = mem[rptr][2*WIDTH-1 -: WIDTH];
    case (state_q)
      WORD_X: begin
        if (beat) state_d = WORD_Z;
      end
      WORD_Z: begin
        out_last = 1'b1;
        out_data = mem[rptr][WIDTH-1:0];
        if (beat) state_d = WORD_X;
      end
      default: state_d = WORD_X;
    endcase
  end

`ifdef XZ_RESULT_FIFO_DROP_CNT_EN
  // Cleared by reset only; flush leaves the diagnostic history intact.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      drop_cnt <= '0;
    else if (in_valid && !in_ready && !flush && (drop_cnt != 16'hFFFF))
      drop_cnt <= drop_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_xz_result_fifo.sv
// Scoreboard bench for xz_result_fifo: expected words queued on push, compared on beats.
module tb_xz_result_fifo;
  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] x = '0;
  logic [31:0] z = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_last;
  logic [2:0]  count;
`ifdef XZ_RESULT_FIFO_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b1;
  logic [32:0] q[$];

  xz_result_fifo #(.WIDTH(32), .DEPTH(4)) dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .x(x), .z(z),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .count(count)
`ifdef XZ_RESULT_FIFO_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  // Beat monitor: inputs are stable from negedge to the following posedge.
  always @(negedge CLK) begin
    if (mon_en && RST && !flush && out_valid && out_ready) begin
      logic [32:0] e;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected: got last=%0b data=%h, none expected", out_last, out_data);
      end else begin
        e = q.pop_front();
        if ({out_last, out_data} !== e) begin
          errors++;
          $display("FAIL beat_word: got last=%0b data=%h, expected last=%0b data=%h",
                   out_last, out_data, e[32], e[31:0]);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge CLK); #1;
  endtask

  task automatic push_pair(input logic [31:0] xv, input logic [31:0] zv, input bit exp_acc);
    x = xv; z = zv; in_valid = 1'b1;
    @(negedge CLK);
    checks++;
    if (in_ready !== exp_acc) begin
      errors++;
      $display("FAIL push_in_ready: x=%h got %0b expected %0b", xv, in_ready, exp_acc);
    end
    if (exp_acc) begin
      q.push_back({1'b0, xv});
      q.push_back({1'b1, zv});
    end
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q.size() != 0 || out_valid) && n < 200) begin
      cyc();
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL drain_timeout: queue=%0d out_valid=%0b", q.size(), out_valid);
    end
    checks++;
    if (count !== 3'd0) begin
      errors++;
      $display("FAIL drain_count: got %0d expected 0", count);
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    #3;
    checks++;
    if ({count, out_valid, out_last, in_ready} !== {3'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: count=%0d ov=%0b ol=%0b ir=%0b expected 0 0 0 1",
               count, out_valid, out_last, in_ready);
    end
`ifdef XZ_RESULT_FIFO_DROP_CNT_EN
    checks++;
    if (drop_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt);
    end
`endif
    cyc(); cyc();
    RST = 1'b1;
    cyc();
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    push_pair(32'h11, 32'h22, 1'b1);
    wait_drain();
  endtask

  task automatic test_fill_stall();
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) push_pair(i, i + 32'h100, i <= 4);
    @(negedge CLK);
    checks++;
    if (count !== 3'd4 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill_full: count=%0d in_ready=%0b expected 4 0", count, in_ready);
    end
`ifdef XZ_RESULT_FIFO_DROP_CNT_EN
    checks++;
    if (drop_cnt !== 16'd1) begin
      errors++;
      $display("FAIL fill_drop_cnt: got %0d expected 1", drop_cnt);
    end
`endif
    cyc();
    out_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    push_pair(32'hA, 32'hB, 1'b1);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      checks++;
      if (out_data !== 32'hB || out_last !== 1'b1 || count !== 3'd1) begin
        errors++;
        $display("FAIL bp_hold: data=%h last=%0b count=%0d expected 0000000b 1 1",
                 out_data, out_last, count);
      end
      cyc();
    end
    out_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_full_push_pop();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_pair(32'h300 + i, 32'h400 + i, 1'b1);
    out_ready = 1'b1;
    cyc();
    push_pair(32'h555, 32'h666, 1'b0);
    out_ready = 1'b0;
    in_valid = 1'b1;
    @(negedge CLK);
    checks++;
    if (count !== 3'd3 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_after_pop: count=%0d in_ready=%0b expected 3 1", count, in_ready);
    end
    q.push_back({1'b0, 32'h555});
    q.push_back({1'b1, 32'h666});
    cyc();
    in_valid = 1'b0;
    checks++;
    if (count !== 3'd4) begin
      errors++;
      $display("FAIL full_repush: count=%0d expected 4", count);
    end
`ifdef XZ_RESULT_FIFO_DROP_CNT_EN
    checks++;
    if (drop_cnt !== 16'd2) begin
      errors++;
      $display("FAIL full_drop_cnt: got %0d expected 2", drop_cnt);
    end
`endif
    out_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_wrap();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push_pair(32'h1000 + i, 32'h2000 + i, 1'b1);
      @(negedge CLK);
      checks++;
      if (count > 3'd1) begin
        errors++;
        $display("FAIL wrap_count: pair %0d count=%0d expected <=1", i, count);
      end
      cyc();
    end
    wait_drain();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_pair(32'h700 + i, 32'h800 + i, 1'b1);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    flush = 1'b1; in_valid = 1'b1; x = 32'hDEAD; z = 32'hBEEF;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    q.delete();
    @(negedge CLK);
    checks++;
    if ({count, out_valid, out_last, in_ready} !== {3'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL flush_state: count=%0d ov=%0b ol=%0b ir=%0b expected 0 0 0 1",
               count, out_valid, out_last, in_ready);
    end
`ifdef XZ_RESULT_FIFO_DROP_CNT_EN
    checks++;
    if (drop_cnt !== 16'd2) begin
      errors++;
      $display("FAIL flush_drop_cnt: got %0d expected 2", drop_cnt);
    end
`endif
    cyc();
    out_ready = 1'b1;
    push_pair(32'h901, 32'h902, 1'b1);
    wait_drain();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_pair(32'hA00 + i, 32'hB00 + i, 1'b1);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    #2;
    mon_en = 1'b0;
    RST = 1'b0;
    #1;
    checks++;
    if ({count, out_valid, out_last, in_ready} !== {3'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL async_reset: count=%0d ov=%0b ol=%0b ir=%0b expected 0 0 0 1",
               count, out_valid, out_last, in_ready);
    end
`ifdef XZ_RESULT_FIFO_DROP_CNT_EN
    checks++;
    if (drop_cnt !== 16'd0) begin
      errors++;
      $display("FAIL async_drop_cnt: got %0d expected 0", drop_cnt);
    end
`endif
    q.delete();
    cyc(); cyc();
    RST = 1'b1;
    mon_en = 1'b1;
    cyc();
    out_ready = 1'b1;
    push_pair(32'hC01, 32'hC02, 1'b1);
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_stall();
    test_backpressure();
    test_full_push_pop();
    test_wrap();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
